// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader. Accepts a 4-byte header
// (n_lines, n_words), then assembles 128-bit instruction lines and 32-bit
// data words, strobing them into imem/dmem while holding the core in reset.
//
// state | meaning
// HDR   | collecting the 4 little-endian header bytes
// IMEM  | assembling 16-byte instruction lines
// DMEM  | assembling 4-byte data words
// DONE  | load complete, core released, stream ignored until reset
module prog_loader #(
  parameter int unsigned           ADDR_LEN  = 32,
  parameter logic [ADDR_LEN-1:0]   IMEM_BASE = '0,
  parameter logic [ADDR_LEN-1:0]   DMEM_BASE = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                prog_loading,
  output logic [ADDR_LEN-1:0] prog_loadaddr,
  output logic [127:0]        prog_loaddata,
  output logic                prog_imem_we,
  output logic                prog_dmem_we,
  output logic                done
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_IMEM = 2'd1,
    S_DMEM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            byte_cnt_q;
  logic [15:0]           n_lines_q, n_words_q;
  logic [15:0]           line_cnt_q, word_cnt_q;
  logic [ADDR_LEN-1:0]   line_ptr_q, word_ptr_q;
  logic [119:0]          line_buf_q;
  logic [23:0]           word_buf_q;
  logic                  in_ready_q, loading_q, done_q;
  logic                  imem_we_q, dmem_we_q;
  logic [ADDR_LEN-1:0]   addr_q;
  logic [127:0]          data_q;
  logic                  accept;

  assign accept        = in_valid && in_ready_q;
  assign in_ready      = in_ready_q;
  assign prog_loading  = loading_q;
  assign prog_loadaddr = addr_q;
  assign prog_loaddata = data_q;
  assign prog_imem_we  = imem_we_q;
  assign prog_dmem_we  = dmem_we_q;
  assign done          = done_q;

  // Next-state decision; the header's n_words high byte is still on in_data
  // when the HDR exit is decided, so it is folded in directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR: begin
        if (accept && byte_cnt_q == 4'd3) begin
          if (n_lines_q != 16'd0)                          state_d = S_IMEM;
          else if ({in_data, n_words_q[7:0]} != 16'd0)     state_d = S_DMEM;
          else                                             state_d = S_DONE;
        end
      end
      S_IMEM: begin
        if (accept && byte_cnt_q == 4'd15 && (line_cnt_q + 16'd1) == n_lines_q)
          state_d = (n_words_q != 16'd0) ? S_DMEM : S_DONE;
      end
      S_DMEM: begin
        if (accept && byte_cnt_q == 4'd3 && (word_cnt_q + 16'd1) == n_words_q)
          state_d = S_DONE;
      end
      default: state_d = S_DONE;
    endcase
  end

  // State, assembly buffers, pointers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_HDR;
      byte_cnt_q <= '0;
      n_lines_q  <= '0;
      n_words_q  <= '0;
      line_cnt_q <= '0;
      word_cnt_q <= '0;
      line_ptr_q <= IMEM_BASE;
      word_ptr_q <= DMEM_BASE;
      line_buf_q <= '0;
      word_buf_q <= '0;
      in_ready_q <= 1'b1;
      loading_q  <= 1'b1;
      done_q     <= 1'b0;
      imem_we_q  <= 1'b0;
      dmem_we_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_DONE);
      imem_we_q  <= 1'b0;
      dmem_we_q  <= 1'b0;
      // Release lags DONE entry by one edge so the last strobe sees loading=1.
      if (state_q == S_DONE) begin
        loading_q <= 1'b0;
        done_q    <= 1'b1;
      end
      if (accept) begin
        case (state_q)
          S_HDR: begin
            case (byte_cnt_q[1:0])
              2'd0:    n_lines_q[7:0]  <= in_data;
              2'd1:    n_lines_q[15:8] <= in_data;
              2'd2:    n_words_q[7:0]  <= in_data;
              default: n_words_q[15:8] <= in_data;
            endcase
            byte_cnt_q <= (byte_cnt_q == 4'd3) ? 4'd0 : byte_cnt_q + 4'd1;
          end
          S_IMEM: begin
            // Shift in from the top: after 15 bytes, byte 0 sits at [7:0].
            line_buf_q <= {in_data, line_buf_q[119:8]};
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'd15) begin
              data_q     <= {in_data, line_buf_q};
              addr_q     <= line_ptr_q;
              imem_we_q  <= 1'b1;
              line_ptr_q <= line_ptr_q + ADDR_LEN'(16);
              line_cnt_q <= line_cnt_q + 16'd1;
            end
          end
          S_DMEM: begin
            word_buf_q <= {in_data, word_buf_q[23:8]};
            byte_cnt_q <= (byte_cnt_q == 4'd3) ? 4'd0 : byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'd3) begin
              data_q     <= {in_data, word_buf_q, 96'd0};
              addr_q     <= word_ptr_q;
              dmem_we_q  <= 1'b1;
              word_ptr_q <= word_ptr_q + ADDR_LEN'(4);
              word_cnt_q <= word_cnt_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready, prog_loading, prog_imem_we, prog_dmem_we, done;
  logic [31:0]  prog_loadaddr;
  logic [127:0] prog_loaddata;

  prog_loader #(.ADDR_LEN(32), .IMEM_BASE(32'h0), .DMEM_BASE(32'h0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .prog_loading(prog_loading),
    .prog_loadaddr(prog_loadaddr), .prog_loaddata(prog_loaddata),
    .prog_imem_we(prog_imem_we), .prog_dmem_we(prog_dmem_we), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         imem;
    logic [31:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  strobe_cnt = 0;
  int  last_strobe_cyc = 0;
  int  prev_strobe_cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe pops the next expected write.
  always @(negedge clk) begin
    if (prog_imem_we || prog_dmem_we) begin
      wr_t e;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual imem=%0b dmem=%0b addr=%0h required none",
                 prog_imem_we, prog_dmem_we, prog_loadaddr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_kind", {126'd0, prog_imem_we, prog_dmem_we}, {126'd0, e.imem, ~e.imem});
        chk("wr_addr", prog_loadaddr, e.addr);
        chk("wr_data", prog_loaddata, e.data);
        chk("wr_loading", prog_loading, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #1 reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // Present one byte; in_valid is left high so consecutive calls are back-to-back.
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual in_ready=0 required 1");
    end
    in_valid = 1'b1;
    in_data  = b;
    tick();
  endtask

  task automatic send_hdr(input logic [15:0] nl, input logic [15:0] nw);
    send(nl[7:0]); send(nl[15:8]); send(nw[7:0]); send(nw[15:8]);
  endtask

  function automatic logic [127:0] line_pat(input logic [7:0] base);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = base + 8'(k);
    return d;
  endfunction

  task automatic send_line(input logic [7:0] base, input int max_gap);
    for (int k = 0; k < 16; k++) begin
      if (max_gap > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) tick();
      end
      send(base + 8'(k));
    end
  endtask

  task automatic push(input logic im, input logic [31:0] a, input logic [127:0] d);
    wr_t e;
    e.imem = im; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int s0;
    logic ready_ok;

    // Reset values
    do_reset();
    chk("rst_loading", prog_loading, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_we", {prog_imem_we, prog_dmem_we}, 0);
    chk("rst_addr", prog_loadaddr, 0);
    chk("rst_data", prog_loaddata, 0);

    // One line and one word
    push(1'b1, 32'h0, 128'h0F0E0D0C0B0A09080706050403020100);
    push(1'b0, 32'h0, {32'hDDCCBBAA, 96'd0});
    send_hdr(16'd1, 16'd1);
    send_line(8'h00, 0);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    in_valid = 1'b0;
    chk("t1_loading_at_write", prog_loading, 1);
    chk("t1_done_at_write", done, 0);
    tick();
    chk("t1_loading_fall", prog_loading, 0);
    chk("t1_done", done, 1);
    chk("t1_ready", in_ready, 0);
    chk("t1_drained", exp_q.size(), 0);

    // Empty header
    do_reset();
    s0 = strobe_cnt;
    send_hdr(16'd0, 16'd0);
    in_valid = 1'b0;
    chk("t2_ready_done_entry", in_ready, 0);
    chk("t2_loading_entry", prog_loading, 1);
    tick();
    chk("t2_loading", prog_loading, 0);
    chk("t2_done", done, 1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("t2_ready_stays0", in_ready, 0);
    chk("t2_done_sticky", done, 1);
    chk("t2_no_strobes", strobe_cnt - s0, 0);

    // Three lines with random gaps
    do_reset();
    s0 = strobe_cnt;
    push(1'b1, 32'h00, line_pat(8'h20));
    push(1'b1, 32'h10, line_pat(8'h40));
    push(1'b1, 32'h20, line_pat(8'h60));
    send_hdr(16'd3, 16'd0);
    send_line(8'h20, 2);
    send_line(8'h40, 2);
    send_line(8'h60, 2);
    in_valid = 1'b0;
    repeat (2) tick();
    chk("t3_done", done, 1);
    chk("t3_strobes", strobe_cnt - s0, 3);
    chk("t3_drained", exp_q.size(), 0);

    // Two words only
    do_reset();
    s0 = strobe_cnt;
    push(1'b0, 32'h0, {32'h44332211, 96'd0});
    push(1'b0, 32'h4, {32'h88776655, 96'd0});
    send_hdr(16'd0, 16'd2);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("t4_strobes", strobe_cnt - s0, 2);
    chk("t4_done", done, 1);
    chk("t4_drained", exp_q.size(), 0);

    // Reset 9 bytes into the second line
    do_reset();
    s0 = strobe_cnt;
    push(1'b1, 32'h0, line_pat(8'h80));
    send_hdr(16'd2, 16'd0);
    send_line(8'h80, 0);
    for (int k = 0; k < 9; k++) send(8'hC0 + 8'(k));
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_loading", prog_loading, 1);
    chk("t5_ready", in_ready, 1);
    chk("t5_done", done, 0);
    chk("t5_we", {prog_imem_we, prog_dmem_we}, 0);
    chk("t5_addr", prog_loadaddr, 0);
    chk("t5_data", prog_loaddata, 0);
    repeat (2) tick();
    chk("t5_no_partial_write", strobe_cnt - s0, 1);
    reset = 1'b0;
    tick();
    push(1'b1, 32'h0, line_pat(8'h30));
    push(1'b0, 32'h0, {32'h04030201, 96'd0});
    send_hdr(16'd1, 16'd1);
    send_line(8'h30, 0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    in_valid = 1'b0;
    repeat (2) tick();
    chk("t5_reload_done", done, 1);
    chk("t5_drained", exp_q.size(), 0);

    // Back-to-back lines
    do_reset();
    push(1'b1, 32'h00, line_pat(8'hA0));
    push(1'b1, 32'h10, line_pat(8'hB0));
    send_hdr(16'd2, 16'd0);
    ready_ok = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (!in_ready) ready_ok = 1'b0;
      send((k < 16) ? (8'hA0 + 8'(k)) : (8'hB0 + 8'(k - 16)));
    end
    in_valid = 1'b0;
    repeat (2) tick();
    chk("t6_ready_held", ready_ok, 1);
    chk("t6_strobe_spacing", last_strobe_cyc - prev_strobe_cyc, 16);
    chk("t6_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
